hex_display_arbiter: RTL and testbench
======================================

Name: hex_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display driver (16-bit hex value in, anode/segment scan out) among NREQ requesters.
- Round-robin arbitration with a guaranteed minimum dwell, so each requester's value stays readable for DWELL cycles before rotation.
- Sits directly upstream of the display driver; its disp_data output feeds the driver's 16-bit data input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL, 50_000_000, minimum ownership in clk cycles when others are waiting (>=1; 0.5 s at 100 MHz).
- IDLE_VALUE, 16'h0000, value driven on disp_data when no owner.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester display request, level, held for as long as the display is wanted.
- req_data  in  NREQ*16  packed values; requester i occupies bits [16*i+15:16*i].
- grant  out  NREQ  one-hot current owner, registered; all-zero when idle.
- owner  out  $clog2(NREQ)  index of current owner; 0 when idle.
- disp_valid  out  1  high while an owner exists.
- disp_data  out  16  registered value for the display driver.

Behaviour:
- Reset (rst high at a clk edge): grant=0, owner=0, disp_valid=0, disp_data=IDLE_VALUE, dwell counter=0, rr pointer=0, state=IDLE.
- States:
  - IDLE: no owner.
  - SHOW: one owner, dwell counter running.
- Round-robin pick: the first asserted req at index >= rr pointer, wrapping modulo NREQ.
  - rr pointer = (last granted index + 1) mod NREQ; updated on every new grant.
- IDLE -> SHOW: at the first edge where any req is high.
  - grant/owner/disp_valid are set at that edge (1-cycle latency from req).
  - Dwell counter cleared to 0.
- In SHOW:
  - Counter increments each cycle and saturates at DWELL-1.
  - "expired" = counter == DWELL-1.
- Rotation (SHOW -> SHOW, new owner) at the edge where expired=1, the owner's req is still high, and some other req is high.
  - New owner comes from the pick over the other requesters only.
  - Counter reset to 0.
  - Under contention each owner holds grant exactly DWELL cycles.
- Expired with no other req: keep the owner indefinitely, counter stays saturated; rotate at the first edge another req appears.
- Owner drops req (any time, dwell or not): at the next edge grant moves to the pick among the remaining reqs (counter cleared), or the block goes to IDLE if none remain. Early release is allowed; dwell only protects against preemption.
- disp_data:
  - Registered every cycle: req_data slice of the owner as granted at that edge, i.e. the new owner's data appears in the same cycle as its grant.
  - Tracks live changes of the owner's data with 1-cycle latency.
  - Equals IDLE_VALUE in IDLE.
- Simultaneous events: owner release and expiry at the same edge is handled as a release (same result). Rotation and a new arrival at the same edge are both covered by the pick over current req.
- Reset mid-SHOW: returns to the reset state at that edge; the rr pointer also returns to 0.
- DWELL=1: rotation is possible every cycle under contention.
- Invariants:
  - grant is one-hot or zero.
  - disp_valid == |grant.
  - owner matches grant.

Decomposition:
- Shared package hex_disp_pkg:
  - state enum {IDLE, SHOW}.
  - HEX_W=16 (display data width).
  - DIGITS=4.
- Sub-module rr_pick: combinational, parameter N.
  - Inputs: req vector, start pointer, exclude mask.
  - Outputs: one-hot grant, index, any.
  - Instantiated once; the exclude mask is used for rotation.

Test Plan (NREQ=4, DWELL=4, IDLE_VALUE=16'h0000; req_data: r0=16'hBF47, r1=16'h1234, r2=16'hDEAD, r3=16'h00FF):
- Reset, then req=0 for 5 cycles -> grant=0, disp_valid=0, disp_data=16'h0000 throughout.
- req=4'b0100 from cycle 0 -> at edge 1 grant=4'b0100, owner=2, disp_data=16'hDEAD; with no contention it holds for 20+ cycles.
- req=4'b1011 held -> grant sequence 0001 (4 cycles), 0010 (4), 1000 (4), 0001 ...; disp_data cycles BF47, 1234, 00FF.
- Owner 0 granted, req[0] dropped after 2 cycles with req[1] high -> grant=4'b0010 at the next edge, before dwell expires; drop all reqs -> IDLE, disp_data=16'h0000.
- Owner 1 holding, r1 changes to 16'hABCD -> disp_data=16'hABCD one cycle later, grant unchanged.
- rst pulsed for 1 cycle mid-SHOW with req=4'b1111 -> next edge reset values; the following edge grant=4'b0001 (pointer back at 0).

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package hex_disp_pkg;

    localparam int DIGITS = 4;
    localparam int HEX_W  = DIGITS * 4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

endpackage

// File: rtl/hex_display_arbiter_rr_pick.sv
// Round-robin picker: first eligible request at or after start_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  excl_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j] && !excl_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner selection for the shared 4-digit hex display, with a
// minimum dwell before an owner can be preempted.
//
// state | meaning
// IDLE  | no owner, display shows IDLE_VALUE
// SHOW  | one owner granted, dwell counter running or saturated
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int               NREQ       = 4,
    parameter int               DWELL      = 50_000_000,
    parameter logic [HEX_W-1:0] IDLE_VALUE = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*HEX_W-1:0]   req_data,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    disp_valid,
    output logic [HEX_W-1:0]        disp_data
);

    localparam int            OW      = $clog2(NREQ);
    localparam int            CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    state_e            state_q;
    logic [NREQ-1:0]   grant_q;
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     rr_q;
    logic [CW-1:0]     cnt_q;
    logic [HEX_W-1:0]  data_q;

    logic [NREQ-1:0]   pick_grant;
    logic [OW-1:0]     pick_idx;
    logic              pick_any;
    logic [NREQ-1:0]   excl;
    logic [OW-1:0]     rr_d;
    logic              owner_req;
    logic              expired;

    // While showing, the current owner is masked so rotation lands on someone else;
    // on release its req is already low, so the mask changes nothing.
    assign excl      = (state_q == SHOW) ? grant_q : '0;
    assign owner_req = req[owner_q];
    assign expired   = (cnt_q == CNT_MAX);
    assign rr_d      = (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    rr_pick #(.N(NREQ), .IW(OW)) u_pick (
        .req_i   (req),
        .start_i (rr_q),
        .excl_i  (excl),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= IDLE_VALUE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= SHOW;
                        grant_q <= pick_grant;
                        owner_q <= pick_idx;
                        rr_q    <= rr_d;
                        cnt_q   <= '0;
                        data_q  <= req_data[int'(pick_idx)*HEX_W +: HEX_W];
                    end
                end
                SHOW: begin
                    if ((!owner_req || expired) && pick_any) begin
                        grant_q <= pick_grant;
                        owner_q <= pick_idx;
                        rr_q    <= rr_d;
                        cnt_q   <= '0;
                        data_q  <= req_data[int'(pick_idx)*HEX_W +: HEX_W];
                    end else if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        owner_q <= '0;
                        cnt_q   <= '0;
                        data_q  <= IDLE_VALUE;
                    end else begin
                        if (!expired) cnt_q <= cnt_q + 1'b1;
                        data_q <= req_data[int'(owner_q)*HEX_W +: HEX_W];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign disp_valid = (state_q == SHOW);
    assign disp_data  = data_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: a behavioural arbiter model predicts each cycle's outputs,
// a monitor compares them against the DUT after every clock edge.
module tb_hex_display_arbiter;

    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*16-1:0]   req_data = '0;
    logic [NREQ-1:0]      grant;
    logic [1:0]           owner;
    logic                 disp_valid;
    logic [15:0]          disp_data;

    hex_display_arbiter #(.NREQ(NREQ), .DWELL(DWELL), .IDLE_VALUE(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .owner      (owner),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd[NREQ];

    // Reference model: owner index (-1 = nobody), cycles the owner has been shown, rr pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (start + k) % NREQ;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic take(input int p);
        m_owner = p;
        m_held  = 1;
        m_ptr   = (p + 1) % NREQ;
    endtask

    task automatic model_edge(input logic r_rst, input logic [3:0] r);
        int p;
        if (r_rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) take(p);
        end else if (!r[m_owner]) begin
            p = pick(r, m_ptr, -1);
            if (p >= 0) take(p);
            else begin m_owner = -1; m_held = 0; end
        end else begin
            p = pick(r, m_ptr, m_owner);
            if (m_held >= DWELL && p >= 0) take(p);
            else m_held++;
        end
    endtask

    task automatic step(input logic r_rst, input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r;
        req_data = {rd[3], rd[2], rd[1], rd[0]};
        model_edge(r_rst, r);
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.owner = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.valid = (m_owner >= 0);
        e.data  = (m_owner >= 0) ? rd[m_owner] : 16'h0000;
        sb.push_back(e);
    endtask

    task automatic run(input logic r_rst, input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) step(r_rst, r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (grant !== e.grant || owner !== e.owner ||
                    disp_valid !== e.valid || disp_data !== e.data) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got grant=%b owner=%0d valid=%b data=%h exp grant=%b owner=%0d valid=%b data=%h",
                             $time, grant, owner, disp_valid, disp_data,
                             e.grant, e.owner, e.valid, e.data);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] r;
        rd[0] = 16'hBF47; rd[1] = 16'h1234; rd[2] = 16'hDEAD; rd[3] = 16'h00FF;

        run(1'b1, 4'b0000, 2);
        run(1'b0, 4'b0000, 5);
        run(1'b0, 4'b0100, 25);
        run(1'b0, 4'b1011, 30);

        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0011, 2);
        run(1'b0, 4'b0010, 3);
        rd[1] = 16'hABCD;
        run(1'b0, 4'b0010, 3);
        run(1'b0, 4'b0000, 3);

        run(1'b0, 4'b1111, 6);
        run(1'b1, 4'b1111, 1);
        run(1'b0, 4'b1111, 10);

        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rd[$urandom_range(0, 3)] = 16'($urandom);
            step($urandom_range(0, 99) == 0, r);
        end
        run(1'b0, 4'b0000, 2);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
